memory: RTL and testbench
=========================

Name: memory

Overview:
- MEMORY (_m) pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Registers the execute-stage results and runs loads/stores on a req/ack data-memory bus. Byte enables, lane alignment and load sign/zero extension are handled here.
- Selects the writeback data and stalls the pipeline while a bus access is outstanding.
- Drives alu_res_m back to execute for forwarding.

Parameters:
- XLEN, 32, datapath/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pc_write_e  in  1  branch/jump write flag from execute
- rd_write_e  in  1  register write enable from execute
- rd_write_src_e  in  2  writeback source: 00 ALU, 01 load, 10 pc+4, 11 CSR
- mem_write_e  in  1  store request
- mem_size_e  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_e  in  5  destination register
- pc_e  in  32  instruction PC
- alu_res_e  in  32  ALU result / effective address
- mem_data_e  in  32  store data (already forwarded)
- csr_data_e  in  32  CSR read data
- stall_m  out  1  to hazard unit: M stage busy
- flush_m  in  1  from hazard unit: clear M register
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  transfer complete
- pc_write_m  out  1  to writeback
- rd_write_m  out  1  to writeback
- rd_m  out  5  to writeback
- pc_m  out  32  to writeback
- alu_res_m  out  32  to writeback / execute forwarding
- rd_data_m  out  32  selected writeback data
- misalign_m  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Pipeline register (all _e inputs):
  - Async reset clears everything to 0.
  - On a clock edge: flush_m clears the register; otherwise it loads when stall_m=0 and holds when stall_m=1.
- Memory-op decode: mem_op = mem_write_m | (rd_write_src_m==01).
- FSM states IDLE, REQ, DONE; reset → IDLE.
  - IDLE/DONE → REQ at the edge that loads a mem_op instruction. Otherwise IDLE/DONE → IDLE.
  - In REQ: dmem_req=1; dmem_we=mem_write_m. On dmem_ack → DONE, and dmem_rdata is captured into load_r.
  - Combinational ack in the first REQ cycle is legal; minimum mem-op occupancy is 2 cycles (REQ, DONE).
- stall_m = (state==REQ). It deasserts in the DONE cycle.
- dmem_be / dmem_wdata from addr[1:0] and size:
  - B: be=0001<<a, data = byte replicated x4.
  - H: be=0011<<{a[1],0}, data = half replicated x2.
  - W: be=1111.
- dmem_be, dmem_we and dmem_wdata are driven to 0 when dmem_req=0.
- Load extract from load_r by addr lane; sign-extend for B/H, zero-extend for BU/HU.
- rd_data_m mux (by rd_write_src_m):
  - 00 → alu_res_m
  - 01 → extended load
  - 10 → pc_m+4 (32-bit wrap)
  - 11 → csr_data_m
- rd_write_m is 0 for stores regardless of the input.
- flush_m while in REQ: the register clears, but the FSM stays in REQ and dmem_req stays high until ack. The transaction is never abandoned on the bus. The FSM then goes → IDLE with data discarded. stall_m stays high until ack.
- Reset mid-transaction: FSM → IDLE; dmem_req drops immediately.
- All outputs reset to 0.

Optional Feature:
- MEMORY_MISALIGN_TRAP_EN.
- Defined:
  - H at a[0]=1 or W at a[1:0]!=0 sets misalign_m=1 for that instruction.
  - No bus request is issued; the FSM goes IDLE→DONE directly.
  - rd_write_m is forced to 0.
- Undefined:
  - misalign_m is tied to 0.
  - Low address bits are ignored (H uses a[1]; W uses the aligned word).

Decomposition:
- Shared defines file (alongside the ALUSRC defines) holds:
  - WB_SRC_ALU/LOAD/PC4/CSR codes
  - MEM_SIZE_B/H/W/BU/HU
  - MEMORY FSM state encodings
- Sub-module load_align: combinational; inputs rdata, addr[1:0], size; output extended 32-bit value.

Test Plan:
- LW: addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF → dmem_req high 3 cycles, stall_m high 3 cycles, rd_data_m=0xDEADBEEF.
- LB at 0x103, rdata 0x80123456 → rd_data_m=0xFFFFFF80. LBU same → 0x00000080. LH at 0x102 → 0xFFFF8012.
- SB 0xAB at 0x101 → dmem_we=1, be=0010, wdata=0xABABABAB, rd_write_m=0.
- ALU op, rd_write_src=10, pc_e=0xFFFFFFFC → rd_data_m=0x00000000, no dmem_req, stall_m=0.
- flush_m asserted in REQ cycle, ack 2 cycles later → dmem_req held until ack, then IDLE, rd_write_m=0. Also: rst_n low mid-REQ → dmem_req=0 immediately.
- With MEMORY_MISALIGN_TRAP_EN: LW at 0x102 → misalign_m=1, no dmem_req, rd_write_m=0, stall_m=0.

Source files
------------

// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Purpose : Shared definitions for the MEMORY (_m) pipeline stage. It holds the
//           writeback source codes, the load/store size codes (funct3), the
//           MEMORY FSM state encoding and the store lane helpers.
// Ports   : none (package)
// Config  : MEMORY_MISALIGN_TRAP_EN (used by memory.sv) enables the
//           misalignment check helper is_misaligned().
// -----------------------------------------------------------------------------
package memory_pkg;

   localparam int XLEN = 32;

   // Writeback data source (rd_write_src)
   localparam logic [1:0] WB_SRC_ALU  = 2'b00;
   localparam logic [1:0] WB_SRC_LOAD = 2'b01;
   localparam logic [1:0] WB_SRC_PC4  = 2'b10;
   localparam logic [1:0] WB_SRC_CSR  = 2'b11;

   // Access size (funct3)
   localparam logic [2:0] MEM_SIZE_B  = 3'b000;
   localparam logic [2:0] MEM_SIZE_H  = 3'b001;
   localparam logic [2:0] MEM_SIZE_W  = 3'b010;
   localparam logic [2:0] MEM_SIZE_BU = 3'b100;
   localparam logic [2:0] MEM_SIZE_HU = 3'b101;

   // MEMORY FSM states
   typedef enum logic [1:0] {
      MEM_IDLE = 2'b00,
      MEM_REQ  = 2'b01,
      MEM_DONE = 2'b10
   } mem_state_t;

   // Byte enables. funct3[1:0] alone tells B/H/W apart; the signed/unsigned
   // bit only matters for loads. Halfwords use addr[1] only.
   function automatic logic [3:0] store_be(input logic [2:0] size,
                                           input logic [1:0] addr);
      logic [3:0] be;
      case (size[1:0])
         2'b00:   be = 4'b0001 << addr;
         2'b01:   be = 4'b0011 << {addr[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicating the datum over every lane means the byte enables alone pick
   // the right lane; no shifter is needed.
   function automatic logic [31:0] store_wdata(input logic [2:0]  size,
                                               input logic [31:0] data);
      logic [31:0] wd;
      case (size[1:0])
         2'b00:   wd = {4{data[7:0]}};
         2'b01:   wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] size,
                                          input logic [1:0] addr);
      logic mis;
      case (size[1:0])
         2'b01:   mis = addr[0];
         2'b10:   mis = (addr != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/memory_load_align.sv
// -----------------------------------------------------------------------------
// memory_load_align
// Purpose : Combinational load lane extraction and sign/zero extension.
// Ports   : i_rdata [31:0]  captured bus read word
//           i_addr  [1:0]   low address bits (byte lane)
//           i_size  [2:0]   funct3 (B, H, W, BU, HU)
//           o_data  [31:0]  extended load value
// -----------------------------------------------------------------------------
module memory_load_align
   import memory_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr,
   input  logic [2:0]  i_size,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   // addr[0] is ignored for halfwords
   assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_data = i_rdata;
      case (i_size)
         MEM_SIZE_B:  o_data = {{24{w_byte[7]}}, w_byte};
         MEM_SIZE_H:  o_data = {{16{w_half[15]}}, w_half};
         MEM_SIZE_BU: o_data = {24'd0, w_byte};
         MEM_SIZE_HU: o_data = {16'd0, w_half};
         default:     o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/memory.sv
// -----------------------------------------------------------------------------
// memory
// Purpose : MEMORY (_m) pipeline stage. Registers the execute results, runs
//           loads/stores on a req/ack data bus, selects the writeback data and
//           stalls the pipeline while a bus access is outstanding.
// Ports   : clk, rst_n                     clock, async active-low reset
//           *_e                            execute-stage results
//           flush_m / stall_m              hazard unit interface
//           dmem_*                         data memory req/ack bus
//           pc_write_m, rd_write_m, rd_m, pc_m, alu_res_m, rd_data_m
//                                          writeback / forwarding
//           misalign_m                     misaligned access flag
// Config  : `define MEMORY_MISALIGN_TRAP_EN to trap misaligned H/W accesses
//           (no bus cycle, rd_write_m suppressed). Without it misalign_m is 0
//           and the low address bits are ignored.
// -----------------------------------------------------------------------------
module memory
   import memory_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_write_e,
   input  logic            rd_write_e,
   input  logic [1:0]      rd_write_src_e,
   input  logic            mem_write_e,
   input  logic [2:0]      mem_size_e,
   input  logic [4:0]      rd_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic [XLEN-1:0] alu_res_e,
   input  logic [XLEN-1:0] mem_data_e,
   input  logic [XLEN-1:0] csr_data_e,
   output logic            stall_m,
   input  logic            flush_m,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            pc_write_m,
   output logic            rd_write_m,
   output logic [4:0]      rd_m,
   output logic [XLEN-1:0] pc_m,
   output logic [XLEN-1:0] alu_res_m,
   output logic [XLEN-1:0] rd_data_m,
   output logic            misalign_m
);

   // Pipeline register
   logic            r_pc_write;
   logic            r_rd_write;
   logic [1:0]      r_wb_src;
   logic            r_mem_write;
   logic [2:0]      r_mem_size;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_alu_res;
   logic [XLEN-1:0] r_csr_data;
   logic            r_misalign;

   // FSM and bus-side state
   mem_state_t      r_state;
   logic            r_flushed;
   logic [XLEN-1:0] r_load;
   logic            r_bus_we;
   logic [XLEN-1:0] r_bus_addr;
   logic [3:0]      r_bus_be;
   logic [XLEN-1:0] r_bus_wdata;

   logic            w_stall;
   logic            w_load_en;
   logic            w_mem_op_e;
   logic            w_misalign_e;
   logic [XLEN-1:0] w_load_ext;

   assign w_stall    = (r_state == MEM_REQ);
   assign w_load_en  = ~flush_m & ~w_stall;
   assign w_mem_op_e = mem_write_e | (rd_write_src_e == WB_SRC_LOAD);

`ifdef MEMORY_MISALIGN_TRAP_EN
   assign w_misalign_e = w_mem_op_e & is_misaligned(mem_size_e, alu_res_e[1:0]);
`else
   assign w_misalign_e = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc_write  <= 1'b0;
         r_rd_write  <= 1'b0;
         r_wb_src    <= WB_SRC_ALU;
         r_mem_write <= 1'b0;
         r_mem_size  <= 3'd0;
         r_rd        <= 5'd0;
         r_pc        <= '0;
         r_alu_res   <= '0;
         r_csr_data  <= '0;
         r_misalign  <= 1'b0;
      end else if (flush_m) begin
         r_pc_write  <= 1'b0;
         r_rd_write  <= 1'b0;
         r_wb_src    <= WB_SRC_ALU;
         r_mem_write <= 1'b0;
         r_mem_size  <= 3'd0;
         r_rd        <= 5'd0;
         r_pc        <= '0;
         r_alu_res   <= '0;
         r_csr_data  <= '0;
         r_misalign  <= 1'b0;
      end else if (!w_stall) begin
         r_pc_write  <= pc_write_e;
         r_rd_write  <= rd_write_e;
         r_wb_src    <= rd_write_src_e;
         r_mem_write <= mem_write_e;
         r_mem_size  <= mem_size_e;
         r_rd        <= rd_e;
         r_pc        <= pc_e;
         r_alu_res   <= alu_res_e;
         r_csr_data  <= csr_data_e;
         r_misalign  <= w_misalign_e;
      end
   end

   // The bus request is captured into its own registers when the access
   // starts, so a flush that clears the pipeline register cannot disturb a
   // transfer already on the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= MEM_IDLE;
         r_flushed   <= 1'b0;
         r_load      <= '0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_be    <= 4'd0;
         r_bus_wdata <= '0;
      end else begin
         case (r_state)
            MEM_IDLE, MEM_DONE: begin
               r_flushed <= 1'b0;
               if (w_load_en && w_mem_op_e) begin
                  r_state     <= w_misalign_e ? MEM_DONE : MEM_REQ;
                  r_bus_we    <= mem_write_e;
                  r_bus_addr  <= {alu_res_e[XLEN-1:2], 2'b00};
                  r_bus_be    <= store_be(mem_size_e, alu_res_e[1:0]);
                  r_bus_wdata <= mem_write_e ? store_wdata(mem_size_e, mem_data_e) : '0;
               end else begin
                  r_state <= MEM_IDLE;
               end
            end
            MEM_REQ: begin
               if (flush_m) r_flushed <= 1'b1;
               if (dmem_ack) begin
                  r_load  <= dmem_rdata;
                  // A flushed access still completes on the bus; its result
                  // is simply dropped.
                  r_state <= (r_flushed || flush_m) ? MEM_IDLE : MEM_DONE;
               end
            end
            default: r_state <= MEM_IDLE;
         endcase
      end
   end

   memory_load_align u_load_align (
      .i_rdata (r_load),
      .i_addr  (r_alu_res[1:0]),
      .i_size  (r_mem_size),
      .o_data  (w_load_ext)
   );

   always_comb begin
      rd_data_m = r_alu_res;
      case (r_wb_src)
         WB_SRC_ALU:  rd_data_m = r_alu_res;
         WB_SRC_LOAD: rd_data_m = w_load_ext;
         WB_SRC_PC4:  rd_data_m = r_pc + 32'd4;
         WB_SRC_CSR:  rd_data_m = r_csr_data;
         default:     rd_data_m = r_alu_res;
      endcase
   end

   assign stall_m    = w_stall;
   assign dmem_req   = w_stall;
   assign dmem_we    = w_stall & r_bus_we;
   assign dmem_addr  = w_stall ? r_bus_addr : '0;
   assign dmem_be    = w_stall ? r_bus_be : 4'd0;
   assign dmem_wdata = w_stall ? r_bus_wdata : '0;

   assign pc_write_m = r_pc_write;
   assign rd_write_m = r_rd_write & ~r_mem_write & ~r_misalign;
   assign rd_m       = r_rd;
   assign pc_m       = r_pc;
   assign alu_res_m  = r_alu_res;
   assign misalign_m = r_misalign;

endmodule

// File: tb/tb_memory.sv
// -----------------------------------------------------------------------------
// tb_memory
// Purpose : Self-checking bench for the MEMORY stage. Each instruction pushes
//           its expected outcome to a scoreboard queue; the entry is popped and
//           compared once the stage has finished with it.
// Config  : honours MEMORY_MISALIGN_TRAP_EN for the misaligned-load case.
// -----------------------------------------------------------------------------
module tb_memory;
   import memory_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        pc_write_e;
   logic        rd_write_e;
   logic [1:0]  rd_write_src_e;
   logic        mem_write_e;
   logic [2:0]  mem_size_e;
   logic [4:0]  rd_e;
   logic [31:0] pc_e;
   logic [31:0] alu_res_e;
   logic [31:0] mem_data_e;
   logic [31:0] csr_data_e;
   logic        stall_m;
   logic        flush_m;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        pc_write_m;
   logic        rd_write_m;
   logic [4:0]  rd_m;
   logic [31:0] pc_m;
   logic [31:0] alu_res_m;
   logic [31:0] rd_data_m;
   logic        misalign_m;

   memory dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_write_e     (pc_write_e),
      .rd_write_e     (rd_write_e),
      .rd_write_src_e (rd_write_src_e),
      .mem_write_e    (mem_write_e),
      .mem_size_e     (mem_size_e),
      .rd_e           (rd_e),
      .pc_e           (pc_e),
      .alu_res_e      (alu_res_e),
      .mem_data_e     (mem_data_e),
      .csr_data_e     (csr_data_e),
      .stall_m        (stall_m),
      .flush_m        (flush_m),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_be        (dmem_be),
      .dmem_wdata     (dmem_wdata),
      .dmem_rdata     (dmem_rdata),
      .dmem_ack       (dmem_ack),
      .pc_write_m     (pc_write_m),
      .rd_write_m     (rd_write_m),
      .rd_m           (rd_m),
      .pc_m           (pc_m),
      .alu_res_m      (alu_res_m),
      .rd_data_m      (rd_data_m),
      .misalign_m     (misalign_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic [31:0] rd_data;
      bit          chk_data;
      logic        rd_write;
      logic        misalign;
      int          bus_cycles;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];

   // Data memory responder: acks after ack_delay wait cycles and records what
   // the DUT showed on the bus.
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   int          req_cnt   = 0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] seen_addr;
   logic [3:0]  seen_be;
   logic        seen_we;
   logic [31:0] seen_wdata;

   always @(negedge clk) begin
      if (dmem_req) begin
         req_cnt++;
         seen_addr  = dmem_addr;
         seen_be    = dmem_be;
         seen_we    = dmem_we;
         seen_wdata = dmem_wdata;
         if (wait_cnt == ack_delay) begin
            dmem_ack   = 1'b1;
            dmem_rdata = mem_rdata;
            wait_cnt   = 0;
         end else begin
            dmem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         dmem_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   task automatic drive_nop();
      pc_write_e     = 1'b0;
      rd_write_e     = 1'b0;
      rd_write_src_e = WB_SRC_ALU;
      mem_write_e    = 1'b0;
      mem_size_e     = MEM_SIZE_B;
      rd_e           = 5'd0;
      pc_e           = '0;
      alu_res_e      = '0;
      mem_data_e     = '0;
      csr_data_e     = '0;
   endtask

   // Called on a falling edge; returns on the falling edge where the
   // instruction's result is visible at the stage outputs.
   task automatic run_op(input string tag, input logic mw, input logic [1:0] src,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] pc,
                         input logic [31:0] csr, input int delay,
                         input logic [31:0] rdata, input bit do_flush,
                         input logic [31:0] x_data, input bit x_chk,
                         input logic x_rdw, input logic x_mis, input int x_cyc,
                         input logic [3:0] x_be, input logic x_we,
                         input logic [31:0] x_wdata);
      exp_t e;
      exp_t got_e;
      int   n;
      e.tag = tag;         e.rd_data = x_data;  e.chk_data = x_chk;
      e.rd_write = x_rdw;  e.misalign = x_mis;  e.bus_cycles = x_cyc;
      e.addr = addr & 32'hFFFF_FFFC;            e.be = x_be;
      e.we = x_we;         e.wdata = x_wdata;   e.pc = pc;
      ack_delay = delay;
      mem_rdata = rdata;
      req_cnt   = 0;
      pc_write_e     = 1'b0;
      rd_write_e     = 1'b1;
      rd_write_src_e = src;
      mem_write_e    = mw;
      mem_size_e     = size;
      rd_e           = 5'd7;
      pc_e           = pc;
      alu_res_e      = addr;
      mem_data_e     = sdata;
      csr_data_e     = csr;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      drive_nop();
      n = 0;
      if (do_flush) begin
         flush_m = 1'b1;
         n = 1;
         @(negedge clk);
         flush_m = 1'b0;
      end
      while (stall_m && n < 50) begin
         n++;
         @(negedge clk);
      end
      got_e = sb.pop_front();
      check_val({got_e.tag, ".stall_cycles"}, n, got_e.bus_cycles);
      check_val({got_e.tag, ".req_cycles"}, req_cnt, got_e.bus_cycles);
      check_val({got_e.tag, ".rd_write_m"}, {31'd0, rd_write_m}, {31'd0, got_e.rd_write});
      check_val({got_e.tag, ".misalign_m"}, {31'd0, misalign_m}, {31'd0, got_e.misalign});
      check_val({got_e.tag, ".stall_after"}, {31'd0, stall_m}, 32'd0);
      if (got_e.chk_data) check_val({got_e.tag, ".rd_data_m"}, rd_data_m, got_e.rd_data);
      if (!do_flush) check_val({got_e.tag, ".pc_m"}, pc_m, got_e.pc);
      if (got_e.bus_cycles > 0) begin
         check_val({got_e.tag, ".dmem_addr"}, seen_addr, got_e.addr);
         check_val({got_e.tag, ".dmem_be"}, {28'd0, seen_be}, {28'd0, got_e.be});
         check_val({got_e.tag, ".dmem_we"}, {31'd0, seen_we}, {31'd0, got_e.we});
         if (got_e.we) check_val({got_e.tag, ".dmem_wdata"}, seen_wdata, got_e.wdata);
      end
      $display("TXN %s rd_data_m=0x%08h rd_write_m=%0b stall_cycles=%0d req_cycles=%0d",
               got_e.tag, rd_data_m, rd_write_m, n, req_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      flush_m = 1'b0;
      drive_nop();
      repeat (2) @(negedge clk);
      check_val("reset.stall_m", {31'd0, stall_m}, 32'd0);
      check_val("reset.dmem_req", {31'd0, dmem_req}, 32'd0);
      check_val("reset.dmem_be", {28'd0, dmem_be}, 32'd0);
      check_val("reset.rd_write_m", {31'd0, rd_write_m}, 32'd0);
      check_val("reset.rd_data_m", rd_data_m, 32'd0);
      check_val("reset.pc_m", pc_m, 32'd0);
      check_val("reset.misalign_m", {31'd0, misalign_m}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      //     tag     mw    src          size         addr          sdata          pc            csr           dly rdata          fl  x_data         chk rdw mis cyc be       we    wdata
      run_op("LW",   1'b0, WB_SRC_LOAD, MEM_SIZE_W,  32'h0000_0100, 32'h0,        32'h0000_1000, 32'h0,        2, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1, 1, 0, 3, 4'b1111, 1'b0, 32'h0);
      run_op("LB",   1'b0, WB_SRC_LOAD, MEM_SIZE_B,  32'h0000_0103, 32'h0,        32'h0000_1004, 32'h0,        0, 32'h80123456, 0, 32'hFFFFFF80, 1, 1, 0, 1, 4'b1000, 1'b0, 32'h0);
      run_op("LBU",  1'b0, WB_SRC_LOAD, MEM_SIZE_BU, 32'h0000_0103, 32'h0,        32'h0000_1008, 32'h0,        1, 32'h80123456, 0, 32'h00000080, 1, 1, 0, 2, 4'b1000, 1'b0, 32'h0);
      run_op("LH",   1'b0, WB_SRC_LOAD, MEM_SIZE_H,  32'h0000_0102, 32'h0,        32'h0000_100C, 32'h0,        0, 32'h80123456, 0, 32'hFFFF8012, 1, 1, 0, 1, 4'b1100, 1'b0, 32'h0);
      run_op("LHU",  1'b0, WB_SRC_LOAD, MEM_SIZE_HU, 32'h0000_0200, 32'h0,        32'h0000_1010, 32'h0,        1, 32'h1234F00D, 0, 32'h0000F00D, 1, 1, 0, 2, 4'b0011, 1'b0, 32'h0);
      run_op("LB0",  1'b0, WB_SRC_LOAD, MEM_SIZE_B,  32'h0000_0204, 32'h0,        32'h0000_1014, 32'h0,        0, 32'h0000007F, 0, 32'h0000007F, 1, 1, 0, 1, 4'b0001, 1'b0, 32'h0);
      run_op("SB",   1'b1, WB_SRC_ALU,  MEM_SIZE_B,  32'h0000_0101, 32'h000000AB, 32'h0000_1018, 32'h0,        1, 32'h0,        0, 32'h00000101, 1, 0, 0, 2, 4'b0010, 1'b1, 32'hABABABAB);
      run_op("SH",   1'b1, WB_SRC_ALU,  MEM_SIZE_H,  32'h0000_0302, 32'h55661234, 32'h0000_101C, 32'h0,        0, 32'h0,        0, 32'h00000302, 1, 0, 0, 1, 4'b1100, 1'b1, 32'h12341234);
      run_op("SW",   1'b1, WB_SRC_ALU,  MEM_SIZE_W,  32'h0000_0304, 32'hCAFEF00D, 32'h0000_1020, 32'h0,        3, 32'h0,        0, 32'h00000304, 1, 0, 0, 4, 4'b1111, 1'b1, 32'hCAFEF00D);
      run_op("PC4",  1'b0, WB_SRC_PC4,  MEM_SIZE_W,  32'h0000_0055, 32'h0,        32'hFFFF_FFFC, 32'h0,        0, 32'h0,        0, 32'h00000000, 1, 1, 0, 0, 4'b0000, 1'b0, 32'h0);
      run_op("ALU",  1'b0, WB_SRC_ALU,  MEM_SIZE_W,  32'h1234_5679, 32'h0,        32'h0000_2000, 32'h0,        0, 32'h0,        0, 32'h12345679, 1, 1, 0, 0, 4'b0000, 1'b0, 32'h0);
      run_op("CSR",  1'b0, WB_SRC_CSR,  MEM_SIZE_W,  32'h0000_0001, 32'h0,        32'h0000_2004, 32'h8765_4321, 0, 32'h0,        0, 32'h87654321, 1, 1, 0, 0, 4'b0000, 1'b0, 32'h0);
      run_op("FLSH", 1'b0, WB_SRC_LOAD, MEM_SIZE_W,  32'h0000_0400, 32'h0,        32'h0000_2008, 32'h0,        2, 32'h11111111, 1, 32'h00000000, 1, 0, 0, 3, 4'b1111, 1'b0, 32'h0);
      run_op("LWb2b",1'b0, WB_SRC_LOAD, MEM_SIZE_W,  32'h0000_0408, 32'h0,        32'h0000_200C, 32'h0,        0, 32'hA5A5_0F0F, 0, 32'hA5A50F0F, 1, 1, 0, 1, 4'b1111, 1'b0, 32'h0);
`ifdef MEMORY_MISALIGN_TRAP_EN
      run_op("LWmis",1'b0, WB_SRC_LOAD, MEM_SIZE_W,  32'h0000_0102, 32'h0,        32'h0000_2010, 32'h0,        0, 32'h11223344, 0, 32'h0,        0, 0, 1, 0, 4'b0000, 1'b0, 32'h0);
`else
      run_op("LWmis",1'b0, WB_SRC_LOAD, MEM_SIZE_W,  32'h0000_0102, 32'h0,        32'h0000_2010, 32'h0,        0, 32'h11223344, 0, 32'h11223344, 1, 1, 0, 1, 4'b1111, 1'b0, 32'h0);
`endif

      // Reset in the middle of an outstanding access
      ack_delay      = 10;
      rd_write_e     = 1'b1;
      rd_write_src_e = WB_SRC_LOAD;
      mem_size_e     = MEM_SIZE_W;
      alu_res_e      = 32'h0000_0500;
      @(posedge clk);
      @(negedge clk);
      drive_nop();
      check_val("rstmid.req_before", {31'd0, dmem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("rstmid.req_now", {31'd0, dmem_req}, 32'd0);
      check_val("rstmid.stall_now", {31'd0, stall_m}, 32'd0);
      check_val("rstmid.rd_write_m", {31'd0, rd_write_m}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rstmid.req_after", {31'd0, dmem_req}, 32'd0);
      $display("TXN RSTMID dmem_req=%0b stall_m=%0b", dmem_req, stall_m);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
